// File: rtl/vga_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_ram_arbiter
// Description : Shares one single-port image RAM between the VGA pixel fetch
//               path (absolute priority, never stalled) and the CPU
//               load/store port (free slots only). CPU writes can be held off
//               during active video. Read data is steered back to its owner
//               through an in-flight tag pipeline matched to the RAM latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ram_arbiter #(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 32,
   parameter int HRES        = 640,
   parameter int VRES        = 480,
   parameter int RD_LAT      = 2,     // legal range 1..4
   parameter int LOCK_ACTIVE = 1,
   parameter int STARVE_MAX  = 1023   // must be >= 1
) (
   input  logic              clk,
   input  logic              rst,
   // raster position
   input  logic [9:0]        x_i,
   input  logic [9:0]        y_i,
   // video fetch port
   input  logic              vid_req_i,
   input  logic [ADDR_W-1:0] vid_addr_i,
   output logic              vid_valid_o,
   output logic [DATA_W-1:0] vid_data_o,
   // CPU load/store port
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_starved_o,
   // RAM port
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_q_i
);

   localparam int                CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  C_WAIT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [9:0]        C_HRES = 10'(HRES);
   localparam logic [9:0]        C_VRES = 10'(VRES);

   typedef enum logic [0:0] {
      ST_BLANK  = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t              state_q;

   logic                lock_w;
   logic                cpu_gnt_w;
   logic                rd_start_w;

   logic [ADDR_W-1:0]   ram_addr_d,  ram_addr_q;
   logic                ram_we_d,    ram_we_q;
   logic [DATA_W-1:0]   ram_wdata_d, ram_wdata_q;

   // Tag pipe: entry k describes the read that reached the RAM k cycles ago.
   // Entry RD_LAT lines up with the cycle in which ram_q carries its data.
   logic [RD_LAT:0]     tag_v_q;
   logic [RD_LAT:0]     tag_cpu_q;

   logic [CNT_W-1:0]    wait_cnt_d, wait_cnt_q;
   logic                starved_q;

   logic                vid_hit_w;
   logic                cpu_hit_w;

   // Raster state tracker: ACTIVE inside the visible window, BLANK elsewhere
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BLANK;
      end else begin
         case (state_q)
            ST_BLANK:  if ((x_i < C_HRES) && (y_i < C_VRES)) state_q <= ST_ACTIVE;
            ST_ACTIVE: if (!((x_i < C_HRES) && (y_i < C_VRES))) state_q <= ST_BLANK;
            default:   state_q <= ST_BLANK;
         endcase
      end
   end

   // Grant: video always wins; CPU writes are blocked while the beam is visible
   always_comb begin
      lock_w     = (LOCK_ACTIVE != 0) && cpu_we_i && (state_q == ST_ACTIVE);
      cpu_gnt_w  = cpu_req_i && !vid_req_i && !rst && !lock_w;
      rd_start_w = vid_req_i || (cpu_gnt_w && !cpu_we_i);
   end

   // Next RAM command: address holds when idle so the RAM sees no needless toggles
   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      if (vid_req_i) begin
         ram_addr_d = vid_addr_i;
      end else if (cpu_gnt_w) begin
         ram_addr_d = cpu_addr_i;
         ram_we_d   = cpu_we_i;
         if (cpu_we_i) begin
            ram_wdata_d = cpu_wdata_i;
         end
      end
   end

   // RAM command register: one access per cycle, issued in grant order
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // In-flight read tags {valid, owner}; owner 1 = CPU, 0 = video.
   // Reset flushes every entry so a read cut off by reset never returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v_q   <= '0;
         tag_cpu_q <= '0;
      end else begin
         tag_v_q   <= {tag_v_q[RD_LAT-1:0],   rd_start_w};
         tag_cpu_q <= {tag_cpu_q[RD_LAT-1:0], !vid_req_i};
      end
   end

   // Starvation wait counter: counts refused request cycles, saturating
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!cpu_req_i || cpu_gnt_w) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != C_WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // Counter register and sticky starvation flag (cleared only by reset)
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
         starved_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         if (wait_cnt_q == C_WAIT_MAX) begin
            starved_q <= 1'b1;
         end
      end
   end

   // Return steering: ram_q is passed straight through to the tagged owner
   always_comb begin
      vid_hit_w = !rst && tag_v_q[RD_LAT] && !tag_cpu_q[RD_LAT];
      cpu_hit_w = !rst && tag_v_q[RD_LAT] &&  tag_cpu_q[RD_LAT];
   end

   // Outputs are forced low while reset is asserted, including the first
   // reset cycle before the registers have cleared.
   assign vid_valid_o   = vid_hit_w;
   assign vid_data_o    = vid_hit_w ? ram_q_i : '0;
   assign cpu_rvalid_o  = cpu_hit_w;
   assign cpu_rdata_o   = cpu_hit_w ? ram_q_i : '0;
   assign cpu_gnt_o     = cpu_gnt_w;
   assign cpu_starved_o = starved_q && !rst;
   assign ram_addr_o    = rst ? '0 : ram_addr_q;
   assign ram_we_o      = ram_we_q && !rst;
   assign ram_wdata_o   = rst ? '0 : ram_wdata_q;

endmodule
`default_nettype wire
